// File: rtl/branch_predictor.sv
// Direct-mapped BTB + 2-bit BHT branch predictor with execute-stage mispredict
// detection, redirect generation and saturating performance counters.
module branch_predictor #(
    parameter int INDEX_BITS = 6,
    parameter int TAG_BITS   = 30 - INDEX_BITS,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                 clk,
    input  logic                 reset_n,
    // fetch-side lookup
    input  logic [31:0]          pc_f,
    output logic                 pred_taken_f,
    output logic [31:0]          pred_target_f,
    // execute-side resolve
    input  logic                 valid_e,
    input  logic                 branch_e,
    input  logic                 jump_e,
    input  logic                 taken_e,
    input  logic [31:0]          pc_e,
    input  logic [31:0]          target_e,
    input  logic                 pred_taken_e,
    input  logic [31:0]          pred_target_e,
    output logic                 mispredict,
    output logic [31:0]          redirect_pc,
    // performance counters
    output logic [CNT_WIDTH-1:0] branch_count,
    output logic [CNT_WIDTH-1:0] mispredict_count
);

    localparam int ENTRIES = 1 << INDEX_BITS;

    logic                btb_valid   [ENTRIES];
    logic [TAG_BITS-1:0] btb_tag     [ENTRIES];
    logic [31:0]         btb_target  [ENTRIES];
    logic                btb_is_jump [ENTRIES];
    logic [1:0]          bht         [ENTRIES];

    logic [INDEX_BITS-1:0] idx_f;
    logic [TAG_BITS-1:0]   tag_f;
    logic                  hit_f;

    logic [INDEX_BITS-1:0] idx_e;
    logic [TAG_BITS-1:0]   tag_e;
    logic                  cf_e;
    logic                  stale_e;
    logic                  dir_miss_e;
    logic                  tgt_miss_e;

    // Lookup reads pre-edge table contents, so a same-cycle update at the
    // same index is only visible from the following cycle.
    always_comb begin
        idx_f         = pc_f[INDEX_BITS+1:2];
        tag_f         = pc_f[31:INDEX_BITS+2];
        hit_f         = btb_valid[idx_f] && (btb_tag[idx_f] == tag_f);
        pred_taken_f  = hit_f && (btb_is_jump[idx_f] || bht[idx_f][1]);
        pred_target_f = pred_taken_f ? btb_target[idx_f] : pc_f + 32'd4;
    end

    // valid_e qualifies every E-stage input: with valid_e=0 the slot is a
    // bubble, nothing is reported and no table or counter moves.
    always_comb begin
        idx_e       = pc_e[INDEX_BITS+1:2];
        tag_e       = pc_e[31:INDEX_BITS+2];
        cf_e        = valid_e && (branch_e || jump_e);
        stale_e     = valid_e && !cf_e && pred_taken_e;
        dir_miss_e  = (taken_e != pred_taken_e);
        tgt_miss_e  = taken_e && (target_e != pred_target_e);
        mispredict  = (cf_e && (dir_miss_e || tgt_miss_e)) || stale_e;
        redirect_pc = (cf_e && taken_e) ? target_e : pc_e + 32'd4;
    end

    // Valid bits and direction counters carry reset state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                btb_valid[i] <= 1'b0;
                bht[i]       <= 2'b01;
            end
        end else begin
            if (cf_e) begin
                if (!jump_e) begin
                    if (taken_e && bht[idx_e] != 2'b11)
                        bht[idx_e] <= bht[idx_e] + 2'b01;
                    else if (!taken_e && bht[idx_e] != 2'b00)
                        bht[idx_e] <= bht[idx_e] - 2'b01;
                end
                if (taken_e)
                    btb_valid[idx_e] <= 1'b1;
            end else if (stale_e) begin
                // A non-control-flow instruction hit an aliasing entry.
                btb_valid[idx_e] <= 1'b0;
            end
        end
    end

    // Payload is only meaningful while the matching valid bit is set.
    always_ff @(posedge clk) begin
        if (cf_e && taken_e) begin
            btb_tag[idx_e]     <= tag_e;
            btb_target[idx_e]  <= target_e;
            btb_is_jump[idx_e] <= jump_e;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            branch_count     <= '0;
            mispredict_count <= '0;
        end else begin
            if (cf_e && branch_count != '1)
                branch_count <= branch_count + CNT_WIDTH'(1);
            if (mispredict && mispredict_count != '1)
                mispredict_count <= mispredict_count + CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed plus randomized bench for branch_predictor, checked against a
// behavioural table model built from the predictor's stated rules.
module tb_branch_predictor;

    logic        clk;
    logic        reset_n;
    logic [31:0] pc_f;
    logic        pred_taken_f;
    logic [31:0] pred_target_f;
    logic        valid_e, branch_e, jump_e, taken_e, pred_taken_e;
    logic [31:0] pc_e, target_e, pred_target_e;
    logic        mispredict;
    logic [31:0] redirect_pc;
    logic [31:0] branch_count, mispredict_count;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    // behavioural model
    bit          m_valid  [64];
    longint      m_tag    [64];
    logic [31:0] m_target [64];
    bit          m_jump   [64];
    int          m_cnt    [64];
    longint      m_bc, m_mc;

    branch_predictor #(.INDEX_BITS(6), .CNT_WIDTH(32)) dut (
        .clk(clk), .reset_n(reset_n),
        .pc_f(pc_f), .pred_taken_f(pred_taken_f), .pred_target_f(pred_target_f),
        .valid_e(valid_e), .branch_e(branch_e), .jump_e(jump_e), .taken_e(taken_e),
        .pc_e(pc_e), .target_e(target_e), .pred_taken_e(pred_taken_e),
        .pred_target_e(pred_target_e), .mispredict(mispredict), .redirect_pc(redirect_pc),
        .branch_count(branch_count), .mispredict_count(mispredict_count)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int idx_of(input logic [31:0] pc);
        return int'((pc / 4) % 64);
    endfunction

    function automatic longint tag_of(input logic [31:0] pc);
        return longint'(pc) / 256;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 64; i++) begin
            m_valid[i] = 0;
            m_cnt[i]   = 1;
        end
        m_bc = 0;
        m_mc = 0;
    endtask

    task automatic model_pred(input logic [31:0] pc, output logic tk, output logic [31:0] tgt);
        int i;
        i  = idx_of(pc);
        tk = m_valid[i] && (m_tag[i] == tag_of(pc)) && (m_jump[i] || m_cnt[i] >= 2);
        tgt = tk ? m_target[i] : pc + 32'd4;
    endtask

    task automatic model_update(input logic v, br, jp, tk, input logic [31:0] pc, tgt,
                                input logic ptk, input logic mp);
        int i;
        i = idx_of(pc);
        if (v && (br || jp)) begin
            if (m_bc < 64'hFFFF_FFFF) m_bc++;
            if (!jp) m_cnt[i] = tk ? ((m_cnt[i] < 3) ? m_cnt[i] + 1 : 3)
                                   : ((m_cnt[i] > 0) ? m_cnt[i] - 1 : 0);
            if (tk) begin
                m_valid[i]  = 1;
                m_tag[i]    = tag_of(pc);
                m_target[i] = tgt;
                m_jump[i]   = jp;
            end
        end else if (v && ptk) begin
            m_valid[i] = 0;
        end
        if (mp && m_mc < 64'hFFFF_FFFF) m_mc++;
    endtask

    // driver: one E-stage resolve plus one fetch lookup, called at a negedge
    task automatic step(input logic v, br, jp, tk, input logic [31:0] pc, tgt,
                        input logic ptk, input logic [31:0] ptgt, input logic [31:0] fpc,
                        input logic use_lit, lit_mp, input logic [31:0] lit_rd);
        logic cf, exp_mp, m_tk;
        logic [31:0] exp_rd, m_tgt;
        valid_e = v; branch_e = br; jump_e = jp; taken_e = tk;
        pc_e = pc; target_e = tgt; pred_taken_e = ptk; pred_target_e = ptgt;
        pc_f = fpc;
        #1;
        cf     = v && (br || jp);
        exp_mp = (cf && (tk != ptk || (tk && tgt != ptgt))) || (v && !cf && ptk);
        exp_rd = (cf && tk) ? tgt : pc + 32'd4;
        model_pred(fpc, m_tk, m_tgt);
        chk("pred_taken_f", 32'(pred_taken_f), 32'(m_tk));
        chk("pred_target_f", pred_target_f, m_tgt);
        chk("mispredict", 32'(mispredict), 32'(exp_mp));
        if (exp_mp) begin
            exp_q.push_back(exp_rd);
            chk("redirect_pc", redirect_pc, exp_q.pop_front());
        end
        if (use_lit) begin
            chk("lit_mispredict", 32'(mispredict), 32'(lit_mp));
            if (lit_mp) chk("lit_redirect", redirect_pc, lit_rd);
        end
        @(posedge clk);
        model_update(v, br, jp, tk, pc, tgt, ptk, exp_mp);
        @(negedge clk);
        chk("branch_count", branch_count, 32'(m_bc));
        chk("mispredict_count", mispredict_count, 32'(m_mc));
    endtask

    task automatic lookup(input logic [31:0] fpc, input logic lit_tk, input logic [31:0] lit_tgt);
        logic m_tk;
        logic [31:0] m_tgt;
        valid_e = 0; branch_e = 0; jump_e = 0; taken_e = 0; pred_taken_e = 0;
        pc_f = fpc;
        #1;
        model_pred(fpc, m_tk, m_tgt);
        chk("lookup_taken_model", 32'(pred_taken_f), 32'(m_tk));
        chk("lookup_taken", 32'(pred_taken_f), 32'(lit_tk));
        chk("lookup_target", pred_target_f, lit_tgt);
        chk("lookup_mispredict", 32'(mispredict), 32'd0);
        @(negedge clk);
    endtask

    initial begin
        logic        v, br, jp, tk, ptk, use_model;
        logic [31:0] pc, tgt, ptgt, fpc, mt;
        logic        mtk;
        int          kind;

        reset_n = 0;
        valid_e = 0; branch_e = 0; jump_e = 0; taken_e = 0; pred_taken_e = 0;
        pc_e = 0; target_e = 0; pred_target_e = 0; pc_f = 32'h100;
        model_reset();
        #2;
        chk("rst_pred_taken", 32'(pred_taken_f), 32'd0);
        chk("rst_pred_target", pred_target_f, 32'h104);
        chk("rst_branch_count", branch_count, 32'd0);
        chk("rst_mispredict_count", mispredict_count, 32'd0);
        chk("rst_mispredict", 32'(mispredict), 32'd0);
        @(negedge clk);
        reset_n = 1;
        @(negedge clk);

        // cold taken branch, then trained lookup
        step(1, 1, 0, 1, 32'h100, 32'h200, 0, 32'h104, 32'h100, 1, 1, 32'h200);
        lookup(32'h100, 1, 32'h200);
        // two not-taken resolves drive the counter 2 -> 1 -> 0
        step(1, 1, 0, 0, 32'h100, 32'h200, 1, 32'h200, 32'h100, 1, 1, 32'h104);
        step(1, 1, 0, 0, 32'h100, 32'h200, 0, 32'h104, 32'h100, 1, 0, 32'h0);
        lookup(32'h100, 0, 32'h104);
        // JAL learned once, then predicted correctly
        step(1, 0, 1, 1, 32'h40, 32'h80, 0, 32'h44, 32'h40, 1, 1, 32'h80);
        lookup(32'h40, 1, 32'h80);
        step(1, 0, 1, 1, 32'h40, 32'h80, 1, 32'h80, 32'h40, 1, 0, 32'h0);
        // JALR with wrong predicted target
        step(1, 0, 1, 1, 32'h44, 32'h300, 1, 32'h280, 32'h44, 1, 1, 32'h300);
        lookup(32'h44, 1, 32'h300);
        // bubble with a would-be mismatch changes nothing
        step(0, 1, 0, 1, 32'h100, 32'h500, 0, 32'h104, 32'h100, 1, 0, 32'h0);
        chk("bubble_branch_count", branch_count, 32'd6);
        chk("bubble_mispredict_count", mispredict_count, 32'd4);
        // non-control-flow instruction that was predicted taken: stale entry
        step(1, 0, 0, 0, 32'h40, 32'h0, 1, 32'h80, 32'h48, 1, 1, 32'h44);
        lookup(32'h40, 0, 32'h44);

        // randomized traffic over a small aliasing PC pool
        for (int n = 0; n < 400; n++) begin
            pc   = 32'h1000 * $urandom_range(0, 2) + 4 * $urandom_range(0, 5);
            tgt  = 32'h2000 + 4 * $urandom_range(0, 15);
            kind = $urandom_range(0, 9);
            v    = (kind != 0);
            br   = (kind >= 4) || (kind == 0 && $urandom_range(0, 1) == 1);
            jp   = (kind == 2 || kind == 3);
            tk   = jp ? 1'b1 : 1'($urandom_range(0, 1));
            use_model = ($urandom_range(0, 3) != 0);
            model_pred(pc, mtk, mt);
            ptk  = use_model ? mtk : 1'($urandom_range(0, 1));
            ptgt = use_model ? mt : (ptk ? tgt : pc + 32'd4);
            fpc  = ($urandom_range(0, 1) == 1) ? pc
                   : 32'h1000 * $urandom_range(0, 2) + 4 * $urandom_range(0, 5);
            step(v, br, jp, tk, pc, tgt, ptk, ptgt, fpc, 0, 0, 32'h0);
        end

        // retrain a known entry, then reset mid-stream
        step(1, 0, 1, 1, 32'h40, 32'h80, 0, 32'h44, 32'h40, 1, 1, 32'h80);
        lookup(32'h40, 1, 32'h80);
        reset_n = 0;
        pc_f = 32'h40;
        #1;
        model_reset();
        chk("midrst_pred_taken", 32'(pred_taken_f), 32'd0);
        chk("midrst_pred_target", pred_target_f, 32'h44);
        chk("midrst_branch_count", branch_count, 32'd0);
        chk("midrst_mispredict_count", mispredict_count, 32'd0);
        @(negedge clk);
        reset_n = 1;
        @(negedge clk);
        lookup(32'h40, 0, 32'h44);
        step(1, 1, 0, 1, 32'h100, 32'h200, 0, 32'h104, 32'h100, 1, 1, 32'h200);
        lookup(32'h100, 1, 32'h200);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
